// File: rtl/rca_pkg.sv
// Shared constants and types for the pipelined ripple-carry adder.
package rca_pkg;

    // Default operand/sum width
    localparam int unsigned RCA_WIDTH = 64;

    // Edges from operand sample to result visible on sum/crout
    localparam int unsigned RCA_LATENCY = 2;

    typedef logic [RCA_WIDTH-1:0] rca_word_t;

endpackage

// File: rtl/rca_64_full_adder.sv
// One-bit combinational full adder; the ripple-chain cell of rca_64.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/rca_64.sv
// Two-stage pipelined ripple-carry adder: registered operands, WIDTH-cell
// full-adder chain, registered sum and carry-out.
// Optional macro RCA64_CARRY_IN_EN adds a registered carry-in port cin.
module rca_64
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH = RCA_WIDTH
) (
    output logic [WIDTH-1:0] sum,
    output logic             crout,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
`ifdef RCA64_CARRY_IN_EN
    input  logic             cin,
`endif
    input  logic             clock,
    input  logic             reset
);

    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op2_q;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH:0]   carry;
    logic             crout_d;
    logic             crout_q;

`ifdef RCA64_CARRY_IN_EN
    logic cin_q;

    // Stage 1 carry-in capture, sampled alongside the operands
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cin_q <= 1'b0;
        end else begin
            cin_q <= cin;
        end
    end

    assign carry[0] = cin_q;
`else
    assign carry[0] = 1'b0;
`endif

    // Stage 1: capture the operand pair
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op1_q <= '0;
            op2_q <= '0;
        end else begin
            op1_q <= op1;
            op2_q <= op2;
        end
    end

    // Ripple chain: no lookahead, the carry walks every bit position
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a  (op1_q[i]),
            .b  (op2_q[i]),
            .ci (carry[i]),
            .s  (sum_d[i]),
            .co (carry[i+1])
        );
    end

    assign crout_d = carry[WIDTH];

    // Stage 2: capture the rippled sum and the MSB carry-out
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q   <= '0;
            crout_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            crout_q <= crout_d;
        end
    end

    assign sum   = sum_q;
    assign crout = crout_q;

endmodule

// File: tb/tb_rca_64.sv
// Self-checking bench for rca_64: directed vectors, random traffic, reset
// pulses and between-edge input changes against an arithmetic reference.
module tb_rca_64;
    import rca_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    rca_word_t   op1;
    rca_word_t   op2;
    rca_word_t   sum;
    logic        crout;
`ifdef RCA64_CARRY_IN_EN
    logic        cin;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Results of every sampled operand pair since reset, oldest first
    logic [RCA_WIDTH:0] hist[$];
    logic [RCA_WIDTH:0] expv;

    always #12 clock = ~clock;

    rca_64 #(
        .WIDTH (RCA_WIDTH)
    ) dut (
        .sum   (sum),
        .crout (crout),
        .op1   (op1),
        .op2   (op2),
`ifdef RCA64_CARRY_IN_EN
        .cin   (cin),
`endif
        .clock (clock),
        .reset (reset)
    );

    function automatic logic [RCA_WIDTH:0] ref_add(input rca_word_t a, input rca_word_t b,
                                                    input logic ci);
        return {1'b0, a} + {1'b0, b} + {{RCA_WIDTH{1'b0}}, ci};
    endfunction

    task automatic chk(input string tag, input rca_word_t es, input logic ec);
        n_cmp++;
        assert (sum === es && crout === ec) else begin
            n_err++;
            $error("FAIL %s: got sum=%h crout=%b, want sum=%h crout=%b",
                   tag, sum, crout, es, ec);
        end
    endtask

    // Output expected now: result sampled RCA_LATENCY edges ago, else reset zeros
    function automatic logic [RCA_WIDTH:0] model_out();
        if (hist.size() >= RCA_LATENCY) return hist[hist.size()-RCA_LATENCY];
        return '0;
    endfunction

    task automatic step(input string tag, input rca_word_t a, input rca_word_t b,
                        input logic ci);
        @(negedge clock);
        op1 = a;
        op2 = b;
`ifdef RCA64_CARRY_IN_EN
        cin = ci;
`endif
        @(posedge clock);
`ifdef RCA64_CARRY_IN_EN
        hist.push_back(ref_add(a, b, ci));
`else
        hist.push_back(ref_add(a, b, 1'b0));
`endif
        #1;
        expv = model_out();
        chk(tag, expv[RCA_WIDTH-1:0], expv[RCA_WIDTH]);
    endtask

    initial begin
        rca_word_t ra;
        rca_word_t rb;
        logic      rc;

        reset = 1'b1;
        op1   = '0;
        op2   = '0;
`ifdef RCA64_CARRY_IN_EN
        cin   = 1'b0;
`endif
        #5;
        chk("reset_t0", '0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        chk("reset_held", '0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        hist.delete();

        step("post_rst0", '0, '0, 1'b0);
        step("post_rst1", '0, '0, 1'b0);

        // Directed vectors back-to-back, each also compared to its literal result
        step("dir_a", 64'hBBBB_CDCD_AAAA_1111, 64'hFFFF_FFFF_FFFF_DDDD, 1'b0);
        step("dir_b", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        chk("lit_a", 64'hBBBB_CDCD_AAA9_EEEE, 1'b1);
        step("dir_c", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("lit_wrap", 64'h0, 1'b1);
        step("dir_d", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
        chk("lit_ones", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        step("dir_e", '0, '0, 1'b0);
        chk("lit_mixed", 64'h1234_5678_9ABC_DF00, 1'b0);

        // Inputs wiggling between edges must not reach the outputs
        step("hold_pre", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        #2;
        op1 = {$urandom, $urandom};
        op2 = {$urandom, $urandom};
        #3;
        expv = model_out();
        chk("hold_mid", expv[RCA_WIDTH-1:0], expv[RCA_WIDTH]);

        // Random traffic with boundary patterns mixed in
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: begin ra = '1; rb = 64'h1; end
                1: begin ra = '1; rb = '1; end
                2: begin ra = '0; rb = '1; end
                default: begin ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; end
            endcase
            rc = 1'($urandom_range(0, 1));
`ifndef RCA64_CARRY_IN_EN
            rc = 1'b0;
`endif
            step("rand", ra, rb, rc);
        end

        // Fill both stages, then pulse reset between edges
        step("fill0", {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        step("fill1", '1, '1, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_pulse_async", '0, 1'b0);
        #2;
        reset = 1'b0;
        hist.delete();
        step("rst_discard", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
        chk("rst_discard_lit", '0, 1'b0);
        step("rst_first", 64'h5, 64'h7, 1'b0);
        chk("rst_first_lit", 64'h0000_0001_0000_0000, 1'b0);
        step("rst_next", '0, '0, 1'b0);
        chk("rst_next_lit", 64'hC, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
